// File: rtl/seg7_pkg.sv
// Segment encoding shared by the 7-segment scan driver and its digit decoder.
// Codes are active-low: bit 7 = DP, bits 6:0 = g..a.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_CODES [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] seg7_code(input logic [3:0] nibble, input logic dp);
        logic [7:0] code;
        code    = SEG_CODES[nibble];
        code[7] = code[7] & ~dp;
        return code;
    endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// Single-digit decoder: hex nibble plus decimal point to active-low segments.
// Purely combinational; a blanked digit keeps its decimal point.
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] code
);

    always_comb begin
        code = seg7_code(nibble, dp);
        if (blank) begin
            code = {~dp, SEG_BLANK[6:0]};
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode display driver with LZ blanking and blink.
// HEX/DIGIT_SEL/FRAME are registered: one cycle behind the scan index and level inputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] DIN,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic [NUM_DIGITS-1:0]   BLINK,
    input  logic                    LOAD,
    input  logic                    EN,
    input  logic                    BLANK_LZ,
    output logic [7:0]              HEX,
    output logic [NUM_DIGITS-1:0]   DIGIT_SEL,
    output logic                    FRAME
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]        scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]        dig_idx_q, dig_idx_d;
    logic [FC_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic                    blink_on_q, blink_on_d;

    logic [4*NUM_DIGITS-1:0] pend_din_q, pend_din_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d;
    logic [4*NUM_DIGITS-1:0] disp_din_q, disp_din_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]   disp_blink_q, disp_blink_d;

    logic [7:0]              hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    frame_q, frame_d;

    logic                    scan_last;
    logic                    boundary;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_lz;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_run;
    logic [7:0]              dec_code;

    // A digit is LZ-blanked when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (disp_din_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    always_comb begin
        cur_nib   = disp_din_q[{dig_idx_q, 2'b00} +: 4];
        cur_dp    = disp_dp_q[dig_idx_q];
        cur_blink = disp_blink_q[dig_idx_q];
        cur_lz    = BLANK_LZ & lz_mask[dig_idx_q];
    end

    seg7_digit_dec u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (cur_lz),
        .code   (dec_code)
    );

    always_comb begin
        scan_cnt_d   = scan_cnt_q;
        dig_idx_d    = dig_idx_q;
        frame_cnt_d  = frame_cnt_q;
        blink_on_d   = blink_on_q;
        pend_din_d   = pend_din_q;
        pend_dp_d    = pend_dp_q;
        pend_blink_d = pend_blink_q;
        disp_din_d   = disp_din_q;
        disp_dp_d    = disp_dp_q;
        disp_blink_d = disp_blink_q;
        hex_d        = dec_code;
        sel_d        = ~(NUM_DIGITS'(1) << dig_idx_q);

        scan_last = (scan_cnt_q == CNT_LAST);
        boundary  = scan_last && (dig_idx_q == IDX_LAST);
        frame_d   = boundary;

        if (scan_last) begin
            scan_cnt_d = '0;
            dig_idx_d  = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + 1'b1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end

        // Display always takes the value pending before this edge, so a LOAD
        // landing on the boundary is deferred a full frame.
        if (boundary) begin
            disp_din_d   = pend_din_q;
            disp_dp_d    = pend_dp_q;
            disp_blink_d = pend_blink_q;
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        if (LOAD) begin
            pend_din_d   = DIN;
            pend_dp_d    = DP;
            pend_blink_d = BLINK;
        end

        if (!EN) begin
            hex_d = SEG_BLANK;
            sel_d = '1;
        end else if (!blink_on_q && cur_blink) begin
            hex_d = SEG_BLANK;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt_q   <= '0;
            dig_idx_q    <= '0;
            frame_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            pend_din_q   <= '0;
            pend_dp_q    <= '0;
            pend_blink_q <= '0;
            disp_din_q   <= '0;
            disp_dp_q    <= '0;
            disp_blink_q <= '0;
            hex_q        <= SEG_BLANK;
            sel_q        <= '1;
            frame_q      <= 1'b0;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            dig_idx_q    <= dig_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_on_q   <= blink_on_d;
            pend_din_q   <= pend_din_d;
            pend_dp_q    <= pend_dp_d;
            pend_blink_q <= pend_blink_d;
            disp_din_q   <= disp_din_d;
            disp_dp_q    <= disp_dp_d;
            disp_blink_q <= disp_blink_d;
            hex_q        <= hex_d;
            sel_q        <= sel_d;
            frame_q      <= frame_d;
        end
    end

    assign HEX       = hex_q;
    assign DIGIT_SEL = sel_q;
    assign FRAME     = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
// Each frame is walked digit by digit from one FRAME pulse to the next.
module tb_seg7_scan_driver;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] DIN;
    logic [3:0]  DP;
    logic [3:0]  BLINK;
    logic        LOAD;
    logic        EN;
    logic        BLANK_LZ;
    logic [7:0]  HEX;
    logic [3:0]  DIGIT_SEL;
    logic        FRAME;

    int total = 0;
    int bad   = 0;
    int ncyc;

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DIN       (DIN),
        .DP        (DP),
        .BLINK     (BLINK),
        .LOAD      (LOAD),
        .EN        (EN),
        .BLANK_LZ  (BLANK_LZ),
        .HEX       (HEX),
        .DIGIT_SEL (DIGIT_SEL),
        .FRAME     (FRAME)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_now(input logic [15:0] din, input logic [3:0] dp, input logic [3:0] bl);
        DIN   = din;
        DP    = dp;
        BLINK = bl;
        LOAD  = 1'b1;
    endtask

    // Steps until FRAME is seen (bounded); n is the number of cycles taken.
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (FRAME !== 1'b1 && n < 40);
    endtask

    // Entered in a FRAME cycle; checks all four digits and returns in the next
    // FRAME cycle. With bl set, LOAD is asserted in the boundary cycle itself.
    task automatic check_frame(input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3,
                               input logic bl, input logic [15:0] bdin,
                               input logic [3:0] bdp, input logic [3:0] bbl);
        logic [7:0] exp_hex [4];
        logic [3:0] sel_exp;
        exp_hex = '{e0, e1, e2, e3};
        chk("frame_pulse", {31'd0, FRAME}, 32'd1);
        step();
        LOAD = 1'b0;
        for (int d = 0; d < 4; d++) begin
            sel_exp = ~(4'b0001 << d);
            chk($sformatf("digit_sel_d%0d", d), {28'd0, DIGIT_SEL}, {28'd0, sel_exp});
            chk($sformatf("hex_d%0d", d), {24'd0, HEX}, {24'd0, exp_hex[d]});
            chk($sformatf("frame_low_d%0d", d), {31'd0, FRAME}, 32'd0);
            if (d < 3) repeat (4) step();
        end
        repeat (2) step();
        if (bl) load_now(bdin, bdp, bbl);
        step();
        LOAD = 1'b0;
    endtask

    initial begin
        RST = 1'b1; DIN = '0; DP = '0; BLINK = '0; LOAD = 1'b0; EN = 1'b1; BLANK_LZ = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_hex", {24'd0, HEX}, 32'hFF);
        chk("rst_sel", {28'd0, DIGIT_SEL}, 32'hF);
        chk("rst_frame", {31'd0, FRAME}, 32'd0);

        // Release with a LOAD of 1234; digit 0 of the zeroed display comes first
        RST = 1'b0;
        load_now(16'h1234, 4'b0000, 4'b0000);
        step();
        LOAD = 1'b0;
        chk("first_sel", {28'd0, DIGIT_SEL}, 32'hE);
        chk("first_hex", {24'd0, HEX}, 32'hC0);
        wait_frame(ncyc);
        chk("first_frame_cycles", ncyc, 15);

        // Frame 1: basic decode
        check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0, 16'h0, 4'h0, 4'h0);

        // Frame 2: LZ on, 0005 loaded but not yet displayed
        BLANK_LZ = 1'b1;
        load_now(16'h0005, 4'b0000, 4'b0000);
        check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0, 16'h0, 4'h0, 4'h0);
        // Frame 3: 0005 blanked; LOAD 0000 in the boundary cycle
        check_frame(8'h92, 8'hFF, 8'hFF, 8'hFF, 1'b1, 16'h0000, 4'h0, 4'h0);
        // Frame 4: boundary LOAD not yet visible
        check_frame(8'h92, 8'hFF, 8'hFF, 8'hFF, 1'b0, 16'h0, 4'h0, 4'h0);
        // Frame 5: 0000 shows only digit 0
        load_now(16'h0105, 4'b0000, 4'b0000);
        check_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 16'h0, 4'h0, 4'h0);
        // Frame 6: 0105, inner zero kept
        check_frame(8'h92, 8'hC0, 8'hF9, 8'hFF, 1'b0, 16'h0, 4'h0, 4'h0);

        // Frame 7: LZ off on 0105; 1234 with DP on digit 1 and blink on digit 0 pending
        BLANK_LZ = 1'b0;
        load_now(16'h1234, 4'b0010, 4'b0001);
        check_frame(8'h92, 8'hC0, 8'hF9, 8'hC0, 1'b0, 16'h0, 4'h0, 4'h0);
        // Frames 8..11: blink phase on, on, off, off
        check_frame(8'h99, 8'h30, 8'hA4, 8'hF9, 1'b0, 16'h0, 4'h0, 4'h0);
        check_frame(8'h99, 8'h30, 8'hA4, 8'hF9, 1'b0, 16'h0, 4'h0, 4'h0);
        check_frame(8'hFF, 8'h30, 8'hA4, 8'hF9, 1'b0, 16'h0, 4'h0, 4'h0);
        check_frame(8'hFF, 8'h30, 8'hA4, 8'hF9, 1'b0, 16'h0, 4'h0, 4'h0);

        // Frame 12: blink back on; AAAA loaded within the frame stays hidden
        load_now(16'hAAAA, 4'b0000, 4'b0000);
        check_frame(8'h99, 8'h30, 8'hA4, 8'hF9, 1'b0, 16'h0, 4'h0, 4'h0);
        // Frame 13: AAAA
        check_frame(8'h88, 8'h88, 8'h88, 8'h88, 1'b0, 16'h0, 4'h0, 4'h0);

        // Frame 14: EN low blanks one cycle later, FRAME keeps its period
        chk("en_before_hex", {24'd0, HEX}, 32'h88);
        EN = 1'b0;
        step();
        chk("en_off_hex", {24'd0, HEX}, 32'hFF);
        chk("en_off_sel", {28'd0, DIGIT_SEL}, 32'hF);
        wait_frame(ncyc);
        chk("en_off_frame_cycles", ncyc, 15);
        chk("en_off_hex_late", {24'd0, HEX}, 32'hFF);
        chk("en_off_sel_late", {28'd0, DIGIT_SEL}, 32'hF);

        // Frame 15: re-enabled
        EN = 1'b1;
        check_frame(8'h88, 8'h88, 8'h88, 8'h88, 1'b0, 16'h0, 4'h0, 4'h0);

        // Mid-frame reset with a fresh pending LOAD of 7777
        repeat (6) step();
        load_now(16'h7777, 4'b1111, 4'b0000);
        step();
        LOAD = 1'b0;
        RST  = 1'b1;
        step();
        chk("midrst_hex", {24'd0, HEX}, 32'hFF);
        chk("midrst_sel", {28'd0, DIGIT_SEL}, 32'hF);
        chk("midrst_frame", {31'd0, FRAME}, 32'd0);
        RST = 1'b0;
        step();
        chk("midrst_first_sel", {28'd0, DIGIT_SEL}, 32'hE);
        chk("midrst_first_hex", {24'd0, HEX}, 32'hC0);
        wait_frame(ncyc);
        chk("midrst_frame_cycles", ncyc, 15);
        check_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0, 16'h0, 4'h0, 4'h0);
        chk("midrst_next_frame", {31'd0, FRAME}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
